// File: rtl/fmul_arbiter_pkg.sv
// Shared FPU types and constants for the fmul arbiter slice.
package fpu_pkg;

  localparam int FMUL_LATENCY = 2;
  localparam int FP_W         = 32;
  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_ID_W     = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fmul_arbiter_if.sv
// Requester-facing bundle: per-requester operand handshake and result strobe.
import fpu_pkg::*;

interface fmul_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]      req_valid;
  logic [FP_W*N_REQ-1:0] req_s;
  logic [FP_W*N_REQ-1:0] req_t;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      resp_valid;
  logic [FP_W-1:0]       resp_d;
  logic                  resp_overflow;
  logic                  resp_underflow;

  modport slave (
    input  req_valid, req_s, req_t,
    output req_ready, resp_valid, resp_d, resp_overflow, resp_underflow
  );

  modport master (
    output req_valid, req_s, req_t,
    input  req_ready, resp_valid, resp_d, resp_overflow, resp_underflow
  );
endinterface

// File: rtl/fmul_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, modulo N_REQ.
import fpu_pkg::*;

module fmul_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  localparam int unsigned NR = N_REQ;

  int unsigned pos;

  // Scan from the farthest offset down to ptr so the closest requester wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int unsigned k = NR; k > 0; k--) begin
      pos = 32'(ptr) + k - 1;
      if (pos >= NR) pos = pos - NR;
      if (req[pos[ID_W-1:0]]) begin
        grant                 = '0;
        grant[pos[ID_W-1:0]]  = 1'b1;
        idx                   = pos[ID_W-1:0];
        any                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one pipelined FP multiplier with tag-routed results.
import fpu_pkg::*;

module fmul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = FMUL_LATENCY,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fmul_arbiter_if.slave        bus,
  output logic [FP_W-1:0]      fmul_s,
  output logic [FP_W-1:0]      fmul_t,
  input  logic [FP_W-1:0]      fmul_d,
  input  logic                 fmul_overflow,
  input  logic                 fmul_underflow,
  output logic [ID_W+1:0]      inflight
);

  localparam int               CNT_W = ID_W + 2;
  localparam logic [N_REQ-1:0] ONE   = 1;

  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gidx;
  logic             any;
  logic             accept;
  tag_t             tag_q [LATENCY];
  logic [N_REQ-1:0] resp_valid_q;
  logic [FP_W-1:0]  resp_d_q;
  logic             resp_ovf_q;
  logic             resp_unf_q;
  logic [CNT_W-1:0] inflight_q;

  fmul_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  // Grant is masked during reset so nothing is accepted in that cycle.
  always_comb begin
    accept        = any & ~rst;
    bus.req_ready = accept ? grant : '0;
    fmul_s        = accept ? bus.req_s[gidx*FP_W +: FP_W] : '0;
    fmul_t        = accept ? bus.req_t[gidx*FP_W +: FP_W] : '0;
  end

  // Advance the pointer past the accepted requester; hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (32'(gidx) == N_REQ - 1) ? '0 : gidx + ID_W'(1);
    end
  end

  // Tag shift register tracks which requester owns each multiplier stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < LATENCY; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{valid: accept, id: TAG_ID_W'(gidx)};
      for (int unsigned k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Capture the multiplier result and strobe its owner; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
      resp_d_q     <= '0;
      resp_ovf_q   <= 1'b0;
      resp_unf_q   <= 1'b0;
    end else if (tag_q[LATENCY-1].valid) begin
      resp_valid_q <= ONE << tag_q[LATENCY-1].id;
      resp_d_q     <= fmul_d;
      resp_ovf_q   <= fmul_overflow;
      resp_unf_q   <= fmul_underflow;
    end else begin
      resp_valid_q <= '0;
    end
  end

  // Outstanding-request count: up on accept, down on each response strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      unique case ({accept, |resp_valid_q})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
      inflight_le_max: assert (32'(inflight_q) <= LATENCY + 1);
    end
  end

  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_d         = resp_d_q;
  assign bus.resp_overflow  = resp_ovf_q;
  assign bus.resp_underflow = resp_unf_q;
  assign inflight           = inflight_q;

endmodule
